// File: rtl/serial_mod_pkg.sv
// Shared types for the serial modulo checker: frame-level FSM encoding.
package serial_mod_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_mod_checker_mod_step.sv
// One MSB-first remainder step: rem_o = (2*rem_i + bit_i) mod DIVISOR, given rem_i < DIVISOR.
module mod_step #(
    parameter int unsigned DIVISOR = 5,
    parameter int unsigned RW      = 3
) (
    input  logic [RW-1:0] rem_i,
    input  logic          bit_i,
    output logic [RW-1:0] rem_o
);

    localparam logic [RW:0] DIV_W = (RW+1)'(DIVISOR);

    logic [RW:0] t;

    // t never exceeds 2*DIVISOR-1, so a single conditional subtract completes the reduction.
    assign t     = {rem_i, bit_i};
    assign rem_o = (t >= DIV_W) ? RW'(t - DIV_W) : t[RW-1:0];

endmodule

// File: rtl/serial_mod_checker.sv
// Frame-based serial divisibility checker: reports (MSB-first frame value) mod DIVISOR
// with a start/valid handshake, a done pulse and a latched result.
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter  int unsigned DIVISOR    = 5,
    parameter  int unsigned FRAME_BITS = 8,
    localparam int unsigned RW         = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1,
    localparam int unsigned CW         = $clog2(FRAME_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          valid_i,
    input  logic          serial_i,
    output logic          busy_o,
    output logic [CW-1:0] bit_count_o,
    output logic          done_o,
    output logic [RW-1:0] remainder_o,
    output logic          divisible_o
);

    if (DIVISOR < 2 || DIVISOR > 65536) begin : g_bad_divisor
        $error("serial_mod_checker: DIVISOR must be in 2..65536");
    end
    if (FRAME_BITS < 1) begin : g_bad_frame_bits
        $error("serial_mod_checker: FRAME_BITS must be at least 1");
    end

    state_t        state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] res_rem_q;
    logic          res_div_q;
    logic [RW-1:0] step_in, step_out;
    logic          accept;
    logic          complete;

    // A start restarts the running remainder from zero, so its bit is the frame's first.
    assign step_in = start_i ? '0 : rem_q;

    mod_step #(
        .DIVISOR (DIVISOR),
        .RW      (RW)
    ) u_step (
        .rem_i (step_in),
        .bit_i (serial_i),
        .rem_o (step_out)
    );

    assign accept = valid_i && (start_i || state_q == ACTIVE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        complete = 1'b0;

        if (start_i) begin
            state_d = ACTIVE;
            rem_d   = valid_i ? step_out : '0;
            cnt_d   = valid_i ? CW'(1) : '0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (valid_i) begin
                        rem_d = step_out;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end

        if (accept && cnt_d == CW'(FRAME_BITS)) begin
            state_d  = DONE;
            complete = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            cnt_q     <= '0;
            res_rem_q <= '0;
            res_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            if (complete) begin
                res_rem_q <= step_out;
                res_div_q <= (step_out == '0);
            end
        end
    end

    assign busy_o      = (state_q == ACTIVE);
    assign done_o      = (state_q == DONE);
    assign bit_count_o = cnt_q;
    assign remainder_o = res_rem_q;
    assign divisible_o = res_div_q;

endmodule
